// File: rtl/reg_alu_seq_pkg.sv
// Shared definitions for the reg_alu_seq micro-sequencer: instruction
// width, field positions, kind encodings and the FSM state type.
package reg_alu_seq_pkg;

    localparam int INSTR_W = 21;

    localparam int KIND_HI = 20;
    localparam int KIND_LO = 19;
    localparam int RD_HI   = 18;
    localparam int RD_LO   = 16;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 14;
    localparam int RA_HI   = 13;
    localparam int RA_LO   = 11;
    localparam int RB_HI   = 10;
    localparam int RB_LO   = 8;

    localparam logic [1:0] KIND_LOADI = 2'b00;
    localparam logic [1:0] KIND_ALU   = 2'b01;
    localparam logic [1:0] KIND_NOP   = 2'b10;
    localparam logic [1:0] KIND_HALT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_alu_seq_mem.sv
// Program store for reg_alu_seq: synchronous write, asynchronous read,
// no reset so the program survives a sequencer reset.
import reg_alu_seq_pkg::*;

module reg_alu_seq_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Write port: one word per enabled edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: fetches 21-bit instructions from a small program memory and
// drives one reg_alu write cycle per LOADI/ALU instruction.
// Optional feature macro: REG_ALU_SEQ_CARRY_EN (registered carry_flag).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | host may load program words; start launches a run at pc=0
// ST_FETCH | ir <= mem[pc]
// ST_EXEC  | drive datapath from ir; advance pc or finish
// ST_DONE  | one-cycle done pulse, pc holds the last executed address
import reg_alu_seq_pkg::*;

module reg_alu_seq #(
    parameter int PROG_DEPTH = 16,
    parameter int PA_W       = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [PA_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [PA_W-1:0]    pc,
    output logic               carry_flag,
    output logic               sel,
    output logic               wr,
    output logic [1:0]         op,
    output logic [2:0]         rd_addr_a,
    output logic [2:0]         rd_addr_b,
    output logic [2:0]         wr_addr,
    output logic [15:0]        d_in,
    input  logic               cout
);

    localparam logic [PA_W-1:0] PC_LAST = PA_W'(PROG_DEPTH - 1);

    state_t             state, state_nxt;
    logic [PA_W-1:0]    pc_nxt;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] mem_rdata;
    logic [1:0]         ir_kind;
    logic               idle;

    assign idle    = (state == ST_IDLE);
    assign ir_kind = ir[KIND_HI:KIND_LO];

    // Program writes are only honoured while idle.
    reg_alu_seq_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (PA_W)
    ) u_mem (
        .clk   (clk),
        .we    (idle && prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (mem_rdata)
    );

    // State, program counter and instruction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == ST_FETCH) begin
                ir <= mem_rdata;
            end
        end
    end

    // Next state, pc update and instruction decode onto the datapath.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        busy      = 1'b0;
        done      = 1'b0;
        sel       = 1'b0;
        wr        = 1'b0;
        op        = 2'b00;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        wr_addr   = 3'd0;
        d_in      = 16'h0000;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pc_nxt    = '0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy      = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                busy = 1'b1;
                case (ir_kind)
                    KIND_LOADI: begin
                        wr      = 1'b1;
                        wr_addr = ir[RD_HI:RD_LO];
                        d_in    = ir[IMM_HI:IMM_LO];
                    end
                    KIND_ALU: begin
                        sel       = 1'b1;
                        wr        = 1'b1;
                        op        = ir[OP_HI:OP_LO];
                        rd_addr_a = ir[RA_HI:RA_LO];
                        rd_addr_b = ir[RB_HI:RB_LO];
                        wr_addr   = ir[RD_HI:RD_LO];
                    end
                    default: begin
                    end
                endcase
                // The last address finishes the run instead of wrapping.
                if (ir_kind == KIND_HALT || pc == PC_LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    pc_nxt    = pc + PA_W'(1);
                    state_nxt = ST_FETCH;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef REG_ALU_SEQ_CARRY_EN
    logic carry_q;

    // Carry is cleared on a new run and captured at the end of each ALU EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else if (idle && start) begin
            carry_q <= 1'b0;
        end else if (state == ST_EXEC && ir_kind == KIND_ALU) begin
            carry_q <= cout;
        end
    end

    assign carry_flag = carry_q;
`else
    logic unused_cout;
    assign unused_cout = cout;
    assign carry_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_alu_seq.sv
// Self-checking bench for reg_alu_seq: a per-run expected trace built from
// the program contents, checked every cycle, plus directed literal checks.
module tb_reg_alu_seq;

    localparam int PROG_DEPTH = 16;
    localparam int PA_W       = 4;

    logic        clk = 1'b0;
    logic        reset, prog_we, start, cout;
    logic [3:0]  prog_addr;
    logic [20:0] prog_data;
    logic        busy, done, carry_flag, sel, wr;
    logic [3:0]  pc;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] d_in;

    always #5 clk = ~clk;

    reg_alu_seq #(.PROG_DEPTH(PROG_DEPTH), .PA_W(PA_W)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .busy(busy), .done(done),
        .pc(pc), .carry_flag(carry_flag), .sel(sel), .wr(wr), .op(op),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
        .d_in(d_in), .cout(cout)
    );

    typedef struct {
        logic        busy, done;
        logic [3:0]  pc;
        logic        sel, wr;
        logic [1:0]  op;
        logic [2:0]  ra, rb, wa;
        logic [15:0] din;
        logic        alu_exec;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [20:0] mem_m [PROG_DEPTH];
    logic [15:0] regs_m [8];
    logic [3:0]  idle_pc = 4'd0;
    logic        model_carry = 1'b0;
    bit          chk_en = 1'b0;
    int          tests = 0;
    int          fails = 0;

    int          wr_count;
    bit          first_seen;
    logic        f_sel;
    logic [1:0]  f_op;
    logic [2:0]  f_ra, f_rb, f_wa, l_wa;
    logic [15:0] f_din, l_din;

    localparam logic [20:0] W_HALT = {2'b11, 19'd0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t blank(input logic [3:0] p);
        exp_t e;
        e.busy = 1'b0; e.done = 1'b0; e.pc = p; e.sel = 1'b0; e.wr = 1'b0;
        e.op = 2'b00; e.ra = 3'd0; e.rb = 3'd0; e.wa = 3'd0; e.din = 16'h0;
        e.alu_exec = 1'b0;
        return e;
    endfunction

    // Expected cycle-by-cycle trace of one run, derived from the program.
    task automatic push_run();
        exp_t e;
        logic [20:0] w;
        for (int i = 0; i < PROG_DEPTH; i++) begin
            w = mem_m[i];
            e = blank(4'(i));
            e.busy = 1'b1;
            exp_q.push_back(e);
            case (w[20:19])
                2'b00: begin e.wr = 1'b1; e.wa = w[18:16]; e.din = w[15:0]; end
                2'b01: begin
                    e.sel = 1'b1; e.wr = 1'b1; e.wa = w[18:16]; e.op = w[15:14];
                    e.ra = w[13:11]; e.rb = w[10:8]; e.alu_exec = 1'b1;
                end
                default: begin end
            endcase
            exp_q.push_back(e);
            if (w[20:19] == 2'b11 || i == PROG_DEPTH - 1) begin
                e = blank(4'(i));
                e.done = 1'b1;
                exp_q.push_back(e);
                break;
            end
        end
    endtask

    // Per-cycle compare against the trace; idle cycles expect quiet outputs.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = blank(idle_pc);
            check("busy", busy, cur.busy);
            check("done", done, cur.done);
            check("pc", pc, cur.pc);
            check("sel", sel, cur.sel);
            check("wr", wr, cur.wr);
            check("op", op, cur.op);
            check("rd_addr_a", rd_addr_a, cur.ra);
            check("rd_addr_b", rd_addr_b, cur.rb);
            check("wr_addr", wr_addr, cur.wa);
            check("d_in", d_in, cur.din);
`ifdef REG_ALU_SEQ_CARRY_EN
            check("carry_flag", carry_flag, model_carry);
`else
            check("carry_flag", carry_flag, 1'b0);
`endif
            if (cur.done) idle_pc = cur.pc;
            if (cur.alu_exec) model_carry = cout;
            if (wr) begin
                wr_count++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    f_sel = sel; f_op = op; f_ra = rd_addr_a; f_rb = rd_addr_b;
                    f_wa = wr_addr; f_din = d_in;
                end
                l_wa = wr_addr; l_din = d_in;
                if (!sel) regs_m[wr_addr] = d_in;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        wr_count = 0;
        first_seen = 1'b0;
    endtask

    task automatic load(input int a, input logic [20:0] w);
        prog_we = 1'b1; prog_addr = 4'(a); prog_data = w;
        tick();
        prog_we = 1'b0;
        mem_m[a] = w;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_carry = 1'b0;
        push_run();
    endtask

    task automatic do_start_write(input int a, input logic [20:0] w);
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'(a); prog_data = w;
        tick();
        start = 1'b0; prog_we = 1'b0;
        mem_m[a] = w;
        model_carry = 1'b0;
        push_run();
    endtask

    // Counts falling edges until done; a HALT at address k shows done on
    // the (2k+3)th falling edge after the accepting edge. Timeout reads as 0.
    task automatic wait_done(input string name, input int exp_edges);
        int n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
        check(name, n, exp_edges);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; prog_we = 1'b0; start = 1'b0; cout = 1'b0;
        prog_addr = 4'd0; prog_data = 21'd0;
        for (int i = 0; i < 8; i++) regs_m[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_pc", pc, 4'd0);
        check("rst_wr", wr, 1'b0);
        check("rst_carry", carry_flag, 1'b0);
        tick();

        // Two immediate loads then HALT at address 2.
        load(0, {2'b00, 3'd3, 16'hcdef});
        load(1, {2'b00, 3'd7, 16'h3210});
        load(2, W_HALT);
        clear_caps();
        do_start();
        wait_done("t1_done_edges", 7);
        check("t1_wr_count", wr_count, 2);
        check("t1_first_wa", f_wa, 3'd3);
        check("t1_first_din", f_din, 16'hcdef);
        check("t1_first_sel", f_sel, 1'b0);
        check("t1_second_wa", l_wa, 3'd7);
        check("t1_second_din", l_din, 16'h3210);
        check("t1_r3", regs_m[3], 16'hcdef);
        check("t1_r7", regs_m[7], 16'h3210);
        check("t1_pc_hold", pc, 4'd2);

        // ALU decode; word 0 written in the same cycle as start.
        load(1, W_HALT);
        cout = 1'b1;
        clear_caps();
        do_start_write(0, {2'b01, 3'd4, 2'b01, 3'd2, 3'd7, 8'h5a});
        wait_done("t2_done_edges", 5);
        check("t2_wr_count", wr_count, 1);
        check("t2_sel", f_sel, 1'b1);
        check("t2_op", f_op, 2'b01);
        check("t2_ra", f_ra, 3'd2);
        check("t2_rb", f_rb, 3'd7);
        check("t2_wa", f_wa, 3'd4);
        check("t2_din", f_din, 16'h0);
`ifdef REG_ALU_SEQ_CARRY_EN
        check("t2_carry_held", carry_flag, 1'b1);
`else
        check("t2_carry_tied", carry_flag, 1'b0);
`endif

        // All NOPs with junk in the other fields: runs off the end, no wrap.
        for (int i = 0; i < PROG_DEPTH; i++) load(i, {2'b10, 3'd5, 16'hffff});
        clear_caps();
        do_start();
        @(negedge clk);
        check("t3_carry_cleared", carry_flag, 1'b0);
        wait_done("t3_done_edges", 2 * PROG_DEPTH);
        check("t3_wr_count", wr_count, 0);
        check("t3_pc_last", pc, 4'd15);
        cout = 1'b0;

        // start and prog_we while busy are ignored.
        load(0, {2'b00, 3'd1, 16'h1111});
        load(1, {2'b00, 3'd2, 16'h2222});
        load(2, W_HALT);
        clear_caps();
        do_start();
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = W_HALT;
        tick();
        tick();
        start = 1'b0; prog_we = 1'b0;
        wait_done("t4_done_edges", 5);
        clear_caps();
        do_start();
        wait_done("t4_rerun_edges", 7);
        check("t4_rerun_wr_count", wr_count, 2);

        // Reset during the EXEC of instruction 1.
        clear_caps();
        do_start();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        idle_pc = 4'd0;
        model_carry = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        check("t5_pc", pc, 4'd0);
        check("t5_wr", wr, 1'b0);
        check("t5_din", d_in, 16'h0);
        tick();
        regs_m[1] = 16'h0;
        regs_m[2] = 16'h0;
        clear_caps();
        do_start();
        wait_done("t5_rerun_edges", 7);
        check("t5_r1", regs_m[1], 16'h1111);
        check("t5_r2", regs_m[2], 16'h2222);
        check("t5_wr_count", wr_count, 2);

        repeat (2) tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
